// File: rtl/pgm_frac_cen.sv
// rtl/pgm_frac_cen.sv - multi-channel fractional clock-enable generator (rate NUM/DEN per channel)
module pgm_frac_cen #(
  parameter int CHANNELS = 2,
  parameter int W        = 10,
  parameter logic [CHANNELS*W-1:0] NUM_INIT = {10'd4, 10'd2},
  parameter logic [CHANNELS*W-1:0] DEN_INIT = {10'd25, 10'd5}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pause,
  input  logic                  cfg_load,
  input  logic [CHANNELS*W-1:0] cfg_num,
  input  logic [CHANNELS*W-1:0] cfg_den,
  output logic                  cfg_ack,
  output logic                  cfg_err,
  output logic [CHANNELS-1:0]   cen,
  output logic [CHANNELS-1:0]   cen_half
);

  logic [CHANNELS*W-1:0] num_sh;
  logic [CHANNELS*W-1:0] den_sh;
  logic [W:0]            acc [CHANNELS];
  logic [W:0]            sum [CHANNELS];
  logic [CHANNELS-1:0]   hit;
  logic [CHANNELS-1:0]   toggle;
  logic                  cfg_valid;

  // acc is one bit wider than num/den so acc+num cannot wrap
  always_comb begin
    cfg_valid = 1'b1;
    hit       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = acc[i] + {1'b0, num_sh[i*W +: W]};
      hit[i] = (sum[i] >= {1'b0, den_sh[i*W +: W]});
      if ((cfg_den[i*W +: W] == '0) || (cfg_num[i*W +: W] > cfg_den[i*W +: W]))
        cfg_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_sh   <= NUM_INIT;
      den_sh   <= DEN_INIT;
      toggle   <= '0;
      cen      <= '0;
      cen_half <= '0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++)
        acc[i] <= '0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_load && cfg_valid) begin
        // a valid load realigns every channel, even while paused
        num_sh   <= cfg_num;
        den_sh   <= cfg_den;
        toggle   <= '0;
        cen      <= '0;
        cen_half <= '0;
        cfg_ack  <= 1'b1;
        for (int i = 0; i < CHANNELS; i++)
          acc[i] <= '0;
      end else begin
        cfg_err <= cfg_load;
        if (pause) begin
          cen      <= '0;
          cen_half <= '0;
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (hit[i]) begin
              acc[i]      <= sum[i] - {1'b0, den_sh[i*W +: W]};
              cen[i]      <= 1'b1;
              cen_half[i] <= toggle[i];
              toggle[i]   <= ~toggle[i];
            end else begin
              acc[i]      <= sum[i];
              cen[i]      <= 1'b0;
              cen_half[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pgm_frac_cen.sv
// tb/tb_pgm_frac_cen.sv - directed self-checking bench for pgm_frac_cen
module tb_pgm_frac_cen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause;
  logic        cfg_load;
  logic [19:0] cfg_num;
  logic [19:0] cfg_den;
  logic        cfg_ack;
  logic        cfg_err;
  logic [1:0]  cen;
  logic [1:0]  cen_half;

  int checks = 0;
  int errors = 0;

  // phase = active edges since last realign with the default 2/5 and 4/25 ratios
  int ph;
  int mis, first_bad, pc0, pc1, hc0;

  pgm_frac_cen dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pause    (pause),
    .cfg_load (cfg_load),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .cen      (cen),
    .cen_half (cen_half)
  );

  always #5 clk = ~clk;

  // ch0 2/5 fires at phases 3,5 mod 5; ch1 4/25 fires at phases 7,13,19,25 mod 25
  function automatic logic [3:0] expect_at(input int p);
    int r0, r1, n0, n1;
    logic e0, e1;
    r0 = p % 5;
    r1 = p % 25;
    e0 = (p > 0) && (r0 == 3 || r0 == 0);
    e1 = (p > 0) && (r1 == 7 || r1 == 13 || r1 == 19 || r1 == 0);
    n0 = 2 * (p / 5) + ((r0 >= 3) ? 1 : 0);
    n1 = 4 * (p / 25) + ((r1 >= 7) ? 1 : 0) + ((r1 >= 13) ? 1 : 0) + ((r1 >= 19) ? 1 : 0);
    return {e1 && (n1 % 2 == 0), e0 && (n0 % 2 == 0), e1, e0};
  endfunction

  task automatic clear_stats();
    mis = 0; first_bad = -1; pc0 = 0; pc1 = 0; hc0 = 0;
  endtask

  task automatic run_cycles(input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!pause) ph++;
      e = pause ? 4'b0000 : expect_at(ph);
      if ({cen_half, cen} !== e) begin
        mis++;
        if (first_bad < 0) first_bad = ph;
      end
      pc0 += int'(cen[0]);
      pc1 += int'(cen[1]);
      hc0 += int'(cen_half[0]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pause = 1'b0; cfg_load = 1'b0; cfg_num = '0; cfg_den = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cen, cen_half, cfg_ack, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000", {cen, cen_half, cfg_ack, cfg_err});
    end
    #2 reset_n = 1'b1;
    ph = 0;
  endtask

  task automatic test_default_rates();
    clear_stats();
    run_cycles(1000);
    checks++;
    if (mis !== 0) begin
      errors++;
      $display("FAIL default_pattern mismatches %0d first phase %0d want 0", mis, first_bad);
    end
    checks++;
    if (pc0 !== 400) begin errors++; $display("FAIL ch0_rate got %0d want 400", pc0); end
    checks++;
    if (pc1 !== 160) begin errors++; $display("FAIL ch1_rate got %0d want 160", pc1); end
  endtask

  task automatic test_cen_half();
    clear_stats();
    run_cycles(1000);
    checks++;
    if (hc0 !== 200) begin errors++; $display("FAIL ch0_half_count got %0d want 200", hc0); end
    checks++;
    if (mis !== 0) begin
      errors++;
      $display("FAIL half_alignment mismatches %0d first phase %0d want 0", mis, first_bad);
    end
  endtask

  task automatic test_pause();
    clear_stats();
    run_cycles(100);
    pause = 1'b1;
    pc0 = 0; pc1 = 0;
    run_cycles(37);
    checks++;
    if (pc0 + pc1 !== 0) begin errors++; $display("FAIL pause_quiet got %0d pulses want 0", pc0 + pc1); end
    pause = 1'b0;
    run_cycles(200);
    checks++;
    if (mis !== 0) begin
      errors++;
      $display("FAIL pause_resume mismatches %0d first phase %0d want 0", mis, first_bad);
    end
  endtask

  task automatic test_cfg_invalid();
    clear_stats();
    run_cycles(7);
    cfg_num = {10'd4, 10'd6}; cfg_den = {10'd25, 10'd5}; cfg_load = 1'b1;
    run_cycles(1);
    cfg_load = 1'b0;
    checks++;
    if ({cfg_ack, cfg_err} !== 2'b01) begin
      errors++; $display("FAIL err_num_gt_den got ack/err %b want 01", {cfg_ack, cfg_err});
    end
    run_cycles(1);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", cfg_err); end
    cfg_num = {10'd4, 10'd2}; cfg_den = {10'd0, 10'd5}; cfg_load = 1'b1;
    run_cycles(1);
    cfg_load = 1'b0;
    checks++;
    if ({cfg_ack, cfg_err} !== 2'b01) begin
      errors++; $display("FAIL err_den_zero got ack/err %b want 01", {cfg_ack, cfg_err});
    end
    run_cycles(100);
    checks++;
    if (mis !== 0) begin
      errors++;
      $display("FAIL invalid_continues mismatches %0d first phase %0d want 0", mis, first_bad);
    end
  endtask

  task automatic test_cfg_valid();
    int bad;
    cfg_num = {10'd0, 10'd5}; cfg_den = {10'd7, 10'd5}; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    checks++;
    if ({cfg_ack, cfg_err, cen} !== 4'b1000) begin
      errors++; $display("FAIL load_ack got ack/err/cen %b want 1000", {cfg_ack, cfg_err, cen});
    end
    @(posedge clk); #1;
    checks++;
    if ({cfg_ack, cen, cen_half} !== 5'b00100) begin
      errors++; $display("FAIL full_rate_first got ack/cen/half %b want 00100", {cfg_ack, cen, cen_half});
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (cen !== 2'b01 || cen_half !== {1'b0, (i % 2 == 0)}) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_rate_zero got %0d bad cycles want 0", bad); end
    cfg_num = {10'd4, 10'd2}; cfg_den = {10'd25, 10'd5}; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    ph = 0;
    checks++;
    if ({cfg_ack, cen} !== 3'b100) begin
      errors++; $display("FAIL reload_ack got ack/cen %b want 100", {cfg_ack, cen});
    end
    clear_stats();
    run_cycles(50);
    checks++;
    if (mis !== 0) begin
      errors++; $display("FAIL reload_pattern mismatches %0d first phase %0d want 0", mis, first_bad);
    end
  endtask

  task automatic test_async_reset_and_load_pause();
    int waited;
    waited = 0;
    while (cen[0] !== 1'b1 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (cen[0] !== 1'b1) begin errors++; $display("FAIL wait_cen got %b want 1", cen[0]); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cen, cen_half} !== 4'b0) begin
      errors++; $display("FAIL async_drop got %b want 0000", {cen, cen_half});
    end
    @(posedge clk); #3 reset_n = 1'b1;
    ph = 0;
    clear_stats();
    run_cycles(100);
    checks++;
    if (mis !== 0) begin
      errors++; $display("FAIL restart_pattern mismatches %0d first phase %0d want 0", mis, first_bad);
    end
    run_cycles(2);
    pause = 1'b1; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    ph = 0;
    checks++;
    if ({cfg_ack, cfg_err, cen} !== 4'b1000) begin
      errors++; $display("FAIL load_pause_ack got %b want 1000", {cfg_ack, cfg_err, cen});
    end
    clear_stats();
    run_cycles(20);
    checks++;
    if (pc0 + pc1 !== 0) begin errors++; $display("FAIL load_pause_quiet got %0d want 0", pc0 + pc1); end
    pause = 1'b0;
    run_cycles(100);
    checks++;
    if (mis !== 0) begin
      errors++; $display("FAIL load_pause_resume mismatches %0d first phase %0d want 0", mis, first_bad);
    end
  endtask

  initial begin
    test_reset();
    test_default_rates();
    test_cen_half();
    test_pause();
    test_cfg_invalid();
    test_cfg_valid();
    test_async_reset_and_load_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
